bnn_frame_loader: RTL and testbench
===================================

Name: bnn_frame_loader

Overview:
- Upstream feeder for the binary convolution layer.
- Accepts a byte-serial stream from the chip's 8-bit input pins and assembles three flat vectors: filter weights, per-filter thresholds, and the multi-channel input image.
- Presents all three statically to the conv layer and holds them until the consumer acknowledges.
- Weights and thresholds are reloadable per frame or retained across frames.

Parameters:
- IMG_IN_SIZE, 28, input image width/height per channel
- KERNEL_SIZE, 3, square kernel size
- BNN_IN_CHANL, 1, input channels
- BNN_OUT_CHANL, 16, output channels (filters)
- NUM_INPUT_BITS, BNN_IN_CHANL*KERNEL_SIZE*KERNEL_SIZE, bits per filter
- THRESHOLD_WIDTH, $clog2(NUM_INPUT_BITS+1), bits per threshold

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  8  stream byte
- data_valid  in  1  data_in valid this cycle
- sof  in  1  start of frame; qualifies first byte of a frame
- cfg_load  in  1  sampled with sof: 1 = frame carries weights+thresholds before image; 0 = image only
- data_ready  out  1  loader can accept a byte
- weights  out  BNN_OUT_CHANL*NUM_INPUT_BITS  packed filter weights
- thresholds  out  BNN_OUT_CHANL*THRESHOLD_WIDTH  packed thresholds
- in_image  out  BNN_IN_CHANL*IMG_IN_SIZE*IMG_IN_SIZE  packed image
- frame_valid  out  1  all outputs complete and stable
- frame_ack  in  1  consumer done with current frame
- err  out  1  one-cycle pulse on protocol error

Behaviour:
- Transfer occurs when data_valid & data_ready on a rising edge.
- Section byte counts (defaults in brackets):
  - W_BYTES = ceil(BNN_OUT_CHANL*NUM_INPUT_BITS/8) [18]
  - T_BYTES = ceil(BNN_OUT_CHANL*THRESHOLD_WIDTH/8) [8]
  - I_BYTES = ceil(image bits/8) [98]
- Packing: byte k of a section writes vector bits [8k +: 8], LSB first. On the final byte, bits beyond the vector width are discarded.
- Byte counter width = $clog2(max section bytes).
- States: IDLE, LOAD_W, LOAD_T, LOAD_I, DONE.
- IDLE:
  - data_ready=1.
  - Transfer with sof=1 writes byte 0 of the first section. Next state is LOAD_W if cfg_load=1 (byte into weights), else LOAD_I (byte into in_image).
  - Transfer with sof=0 discards the byte and pulses err.
- LOAD_W: after the W_BYTES-th byte -> LOAD_T, counter cleared.
- LOAD_T: after the T_BYTES-th byte -> LOAD_I, counter cleared.
- LOAD_I: after the I_BYTES-th byte -> DONE; frame_valid=1 from the following cycle.
- DONE:
  - data_ready=0, frame_valid=1; all output vectors frozen.
  - frame_ack=1 -> IDLE next cycle. frame_valid=0 and data_ready=1 in that same next cycle.
  - frame_ack is ignored outside DONE.
- Section edge cases:
  - A one-byte section completes and advances on that byte.
- sof=1 on a transfer while in LOAD_W/T/I:
  - Abort the current frame and pulse err.
  - Treat the byte as byte 0 of a new frame using the current cfg_load.
  - Partially written vectors are not cleared.
  - weights/thresholds are valid only after a complete cfg_load=1 frame.
- Image-only frame (cfg_load=0) reuses the weights/thresholds registers untouched.
- Throughput: one byte per cycle sustained; data_valid gaps allowed anywhere with no timeout.
- Reset (asynchronous assert, any state):
  - state=IDLE, counter=0, all vectors=0.
  - frame_valid=0, err=0, data_ready=1 after release.
- Latency: frame_valid rises exactly one cycle after the last image byte's transfer edge.

Decomposition:
- Package bnn_pkg holds:
  - default geometry constants
  - derived W_BYTES/T_BYTES/I_BYTES functions
  - loader state enum type
- Sub-module bnn_byte_packer: parameterized WIDTH register with write-enable, byte index, and byte data. Writes the addressed 8-bit lane with truncation on the final lane. Instantiated three times (weights, thresholds, image).
- FSM and counter live in bnn_frame_loader.

Test Plan:
- Reset then cfg_load=1 frame:
  - Stimulus: 18 weight bytes 0xA5, 8 threshold bytes 0x77, 98 image bytes 0xFF, contiguous.
  - Response: frame_valid=1 one cycle after byte 124; weights = 144 bits alternating pattern from 0xA5; thresholds all 0x7; in_image all ones (784 bits; upper 0 bits of byte 98 discarded); data_ready=0 until frame_ack.
- Image-only frame after the above:
  - Stimulus: cfg_load=0 frame of 98 bytes 0x00 with random data_valid gaps.
  - Response: in_image=0; weights/thresholds unchanged; frame_valid after byte 98 only.
- Stray byte:
  - Stimulus: data_valid=1, sof=0 in IDLE.
  - Response: err pulses 1 cycle; state stays IDLE; no vector changes.
- Restart mid-frame:
  - Stimulus: sof=1 at image byte 40.
  - Response: err pulse; counter restarts; frame_valid only after a further full frame.
- Ack handshake:
  - Stimulus: hold data_valid=1 during DONE, then frame_ack=1.
  - Response: no bytes accepted while DONE; IDLE and data_ready=1 the cycle after ack.
- Async reset at weight byte 10:
  - Stimulus: pulse rst_n low.
  - Response: outputs zero immediately without a clock edge; frame_valid=0; next sof frame loads normally.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared geometry defaults, section byte-count helpers and loader state type
// for the binary-network frame loader.
`timescale 1ns/1ps
package bnn_pkg;

    localparam int IMG_IN_SIZE_D   = 28;
    localparam int KERNEL_SIZE_D   = 3;
    localparam int BNN_IN_CHANL_D  = 1;
    localparam int BNN_OUT_CHANL_D = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_T = 3'd2,
        ST_LOAD_I = 3'd3,
        ST_DONE   = 3'd4
    } loader_state_e;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int w_bytes(input int out_chanl, input int num_input_bits);
        return bytes_for(out_chanl * num_input_bits);
    endfunction

    function automatic int t_bytes(input int out_chanl, input int threshold_width);
        return bytes_for(out_chanl * threshold_width);
    endfunction

    function automatic int i_bytes(input int in_chanl, input int img_size);
        return bytes_for(in_chanl * img_size * img_size);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bnn_byte_packer.sv
// Flat vector register written one byte lane at a time; lanes past the
// vector width are dropped so the final byte may be partial.
`timescale 1ns/1ps
module bnn_byte_packer #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] vec
);

    // Lane write: each vector bit picks up its byte-lane bit when addressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (we) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (idx == IDX_W'(b / 8)) begin
                    vec[b] <= data[3'(b % 8)];
                end
            end
        end
    end

endmodule

// File: rtl/bnn_frame_loader.sv
// Byte-serial frame loader: assembles weights, thresholds and image vectors
// and holds them for the conv layer until frame_ack.
`timescale 1ns/1ps
module bnn_frame_loader
    import bnn_pkg::*;
#(
    parameter int IMG_IN_SIZE     = IMG_IN_SIZE_D,
    parameter int KERNEL_SIZE     = KERNEL_SIZE_D,
    parameter int BNN_IN_CHANL    = BNN_IN_CHANL_D,
    parameter int BNN_OUT_CHANL   = BNN_OUT_CHANL_D,
    parameter int NUM_INPUT_BITS  = BNN_IN_CHANL * KERNEL_SIZE * KERNEL_SIZE,
    parameter int THRESHOLD_WIDTH = $clog2(NUM_INPUT_BITS + 1)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [7:0]                                data_in,
    input  logic                                      data_valid,
    input  logic                                      sof,
    input  logic                                      cfg_load,
    output logic                                      data_ready,
    output logic [BNN_OUT_CHANL*NUM_INPUT_BITS-1:0]   weights,
    output logic [BNN_OUT_CHANL*THRESHOLD_WIDTH-1:0]  thresholds,
    output logic [BNN_IN_CHANL*IMG_IN_SIZE*IMG_IN_SIZE-1:0] in_image,
    output logic                                      frame_valid,
    input  logic                                      frame_ack,
    output logic                                      err
);

    localparam int W_BITS  = BNN_OUT_CHANL * NUM_INPUT_BITS;
    localparam int T_BITS  = BNN_OUT_CHANL * THRESHOLD_WIDTH;
    localparam int I_BITS  = BNN_IN_CHANL * IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int W_BYTES = w_bytes(BNN_OUT_CHANL, NUM_INPUT_BITS);
    localparam int T_BYTES = t_bytes(BNN_OUT_CHANL, THRESHOLD_WIDTH);
    localparam int I_BYTES = i_bytes(BNN_IN_CHANL, IMG_IN_SIZE);
    localparam int MAX_B   = max3(W_BYTES, T_BYTES, I_BYTES);
    localparam int CNT_W   = (MAX_B > 1) ? $clog2(MAX_B) : 1;

    loader_state_e    state_r;
    loader_state_e    state_n_s;
    loader_state_e    sec_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n_s;
    logic [CNT_W-1:0] idx_s;
    logic [CNT_W-1:0] sec_last_s;
    logic             xfer_s;
    logic             wr_s;
    logic             err_s;
    logic             ready_r;
    logic             valid_r;
    logic             err_r;

    assign xfer_s      = data_valid & ready_r;
    assign data_ready  = ready_r;
    assign frame_valid = valid_r;
    assign err         = err_r;

    // Decide which section (if any) the current byte lands in, and at what index.
    always_comb begin
        sec_s = ST_IDLE;
        idx_s = '0;
        wr_s  = 1'b0;
        err_s = 1'b0;
        if (xfer_s && sof) begin
            // A start-of-frame always begins a new frame; mid-frame it aborts the old one.
            wr_s  = 1'b1;
            sec_s = cfg_load ? ST_LOAD_W : ST_LOAD_I;
            err_s = (state_r != ST_IDLE);
        end else if (xfer_s && (state_r == ST_IDLE)) begin
            err_s = 1'b1;
        end else if (xfer_s) begin
            wr_s  = 1'b1;
            sec_s = state_r;
            idx_s = cnt_r;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Last byte index of the section being written.
    always_comb begin
        case (sec_s)
            ST_LOAD_W: sec_last_s = CNT_W'(W_BYTES - 1);
            ST_LOAD_T: sec_last_s = CNT_W'(T_BYTES - 1);
            ST_LOAD_I: sec_last_s = CNT_W'(I_BYTES - 1);
            default:   sec_last_s = '0;
        endcase
    end

    // Next state and byte counter.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        if (wr_s) begin
            if (idx_s == sec_last_s) begin
                cnt_n_s = '0;
                case (sec_s)
                    ST_LOAD_W: state_n_s = ST_LOAD_T;
                    ST_LOAD_T: state_n_s = ST_LOAD_I;
                    default:   state_n_s = ST_DONE;
                endcase
            end else begin
                cnt_n_s   = idx_s + CNT_W'(1);
                state_n_s = sec_s;
            end
        end else if ((state_r == ST_DONE) && frame_ack) begin
            state_n_s = ST_IDLE;
        end else begin
            state_n_s = state_r;
        end
    end

    // State, counter and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            ready_r <= (state_n_s != ST_DONE);
            valid_r <= (state_n_s == ST_DONE);
            err_r   <= err_s;
        end
    end

    bnn_byte_packer #(.WIDTH(W_BITS), .IDX_W(CNT_W)) u_weights (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_s && (sec_s == ST_LOAD_W)),
        .idx   (idx_s),
        .data  (data_in),
        .vec   (weights)
    );

    bnn_byte_packer #(.WIDTH(T_BITS), .IDX_W(CNT_W)) u_thresholds (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_s && (sec_s == ST_LOAD_T)),
        .idx   (idx_s),
        .data  (data_in),
        .vec   (thresholds)
    );

    bnn_byte_packer #(.WIDTH(I_BITS), .IDX_W(CNT_W)) u_image (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_s && (sec_s == ST_LOAD_I)),
        .idx   (idx_s),
        .data  (data_in),
        .vec   (in_image)
    );

endmodule

// File: tb/tb_bnn_frame_loader.sv
// Directed and randomized bench for bnn_frame_loader with a frame-position
// reference model.
`timescale 1ns/1ps
module tb_bnn_frame_loader;

    localparam int WBITS = 144;
    localparam int TBITS = 64;
    localparam int IBITS = 784;
    localparam int WB    = 18;
    localparam int TB    = 8;
    localparam int IB    = 98;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             sof;
    logic             cfg_load;
    logic             data_ready;
    logic [WBITS-1:0] weights;
    logic [TBITS-1:0] thresholds;
    logic [IBITS-1:0] in_image;
    logic             frame_valid;
    logic             frame_ack;
    logic             err;

    always #5 clk = ~clk;

    bnn_frame_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .sof         (sof),
        .cfg_load    (cfg_load),
        .data_ready  (data_ready),
        .weights     (weights),
        .thresholds  (thresholds),
        .in_image    (in_image),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err         (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 receiving a frame, 2 holding a complete frame.
    int               m_state;
    int               m_pos;
    logic             m_cfg;
    logic             m_err;
    logic [WBITS-1:0] m_w;
    logic [TBITS-1:0] m_t;
    logic [IBITS-1:0] m_i;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pos   = 0;
        m_cfg   = 1'b0;
        m_err   = 1'b0;
        m_w     = '0;
        m_t     = '0;
        m_i     = '0;
    endtask

    task automatic model_write(input logic [7:0] d);
        int p;
        int total;
        p     = m_pos;
        total = m_cfg ? (WB + TB + IB) : IB;
        if (m_cfg && p < WB) begin
            for (int b = 0; b < 8; b++) if (8*p + b < WBITS) m_w[8*p + b] = d[b];
        end else if (m_cfg && p < WB + TB) begin
            p = p - WB;
            for (int b = 0; b < 8; b++) if (8*p + b < TBITS) m_t[8*p + b] = d[b];
        end else begin
            if (m_cfg) p = p - WB - TB;
            for (int b = 0; b < 8; b++) if (8*p + b < IBITS) m_i[8*p + b] = d[b];
        end
        m_pos++;
        if (m_pos == total) m_state = 2;
    endtask

    task automatic model_step(input logic v, input logic s, input logic c, input logic [7:0] d, input logic ack);
        m_err = 1'b0;
        if (m_state == 2) begin
            if (ack) m_state = 0;
        end else if (v) begin
            if (s) begin
                if (m_state == 1) m_err = 1'b1;
                m_cfg   = c;
                m_pos   = 0;
                m_state = 1;
                model_write(d);
            end else if (m_state == 0) begin
                m_err = 1'b1;
            end else begin
                model_write(d);
            end
        end
    endtask

    task automatic check_all();
        chk("data_ready",  data_ready,  (m_state != 2));
        chk("frame_valid", frame_valid, (m_state == 2));
        chk("err",         err,         m_err);
        chk("weights",     weights,     m_w);
        chk("thresholds",  thresholds,  m_t);
        chk("in_image",    in_image,    m_i);
    endtask

    task automatic cycle(input logic v, input logic s, input logic c, input logic [7:0] d, input logic ack);
        @(negedge clk);
        data_valid = v;
        sof        = s;
        cfg_load   = c;
        data_in    = d;
        frame_ack  = ack;
        model_step(v, s, c, d, ack);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [WBITS-1:0] w_a5;
        logic [TBITS-1:0] t_77;
        int sent;
        int guard;
        logic v;

        w_a5 = {18{8'hA5}};
        t_77 = {16{4'h7}};
        rst_n = 1'b0; data_in = 8'h00; data_valid = 1'b0; sof = 1'b0;
        cfg_load = 1'b0; frame_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();

        // Full configuration frame, contiguous.
        cycle(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0);
        for (int k = 1; k < WB; k++) cycle(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
        for (int k = 0; k < TB; k++) cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
        for (int k = 0; k < IB; k++) cycle(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        chk("frame1_valid",   frame_valid, 1'b1);
        chk("frame1_weights", weights, w_a5);
        chk("frame1_thresh",  thresholds, t_77);
        chk("frame1_image",   in_image, {IBITS{1'b1}});

        // Bytes offered while holding a frame must be refused.
        for (int k = 0; k < 3; k++) cycle(1'b1, (k == 0), 1'b0, 8'($urandom), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("ack_ready", data_ready, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Image-only frame with random valid gaps.
        sent = 0;
        guard = 0;
        while (sent < IB && guard < 2000) begin
            v = ($urandom_range(0, 2) != 0);
            cycle(v, v && (sent == 0), 1'b0, 8'h00, 1'b0);
            if (v) sent++;
            guard++;
        end
        chk("frame2_sent",    sent, IB);
        chk("frame2_image",   in_image, {IBITS{1'b0}});
        chk("frame2_weights", weights, w_a5);
        chk("frame2_thresh",  thresholds, t_77);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Stray byte in IDLE.
        cycle(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
        chk("stray_err", err, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("stray_err_clear", err, 1'b0);

        // Restart at image byte 40 of an image-only frame.
        cycle(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int k = 1; k < 40; k++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        chk("restart_err", err, 1'b1);
        for (int k = 1; k < IB; k++) begin
            chk("restart_no_early_valid", frame_valid, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        end
        chk("restart_valid", frame_valid, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Async reset during weight byte 10.
        cycle(1'b1, 1'b1, 1'b1, 8'($urandom_range(1, 255)), 1'b0);
        for (int k = 1; k < 10; k++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0);
        @(negedge clk);
        data_valid = 1'b1; sof = 1'b0; data_in = 8'h5A;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_weights", weights, {WBITS{1'b0}});
        chk("rst_thresh",  thresholds, {TBITS{1'b0}});
        chk("rst_image",   in_image, {IBITS{1'b0}});
        chk("rst_valid",   frame_valid, 1'b0);
        chk("rst_err",     err, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        data_valid = 1'b0;
        #1;
        check_all();

        // Fresh random configuration frame after reset.
        cycle(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b0);
        for (int k = 1; k < WB + TB + IB; k++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("post_rst_valid", frame_valid, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
